// File: rtl/pipe_rate_change_ctrl_pkg.sv
// Shared PIPE rate-change definitions: FSM encoding, generation limits and the
// gen -> Rate / PCLKRate encodings that mainLTSSM also uses.
package pcie_rate_defs;

  localparam logic [2:0] GEN_MIN     = 3'd1;
  localparam logic [2:0] GEN_MAX_ABS = 3'd5;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_QUIESCE_ENC = 3'd1;
  localparam logic [2:0] ST_RATE_ENC    = 3'd2;
  localparam logic [2:0] ST_ACK_ENC     = 3'd3;
  localparam logic [2:0] ST_DONE_ENC    = 3'd4;
  localparam logic [2:0] ST_ABORT_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_QUIESCE = ST_QUIESCE_ENC,
    ST_RATE    = ST_RATE_ENC,
    ST_ACK     = ST_ACK_ENC,
    ST_DONE    = ST_DONE_ENC,
    ST_ABORT   = ST_ABORT_ENC
  } rcState_e;

  function automatic logic [3:0] genToRate(input logic [2:0] gen);
    return {1'b0, gen - 3'd1};
  endfunction

  function automatic logic [4:0] genToPclkRate(input logic [2:0] gen);
    return {2'b00, gen - 3'd1};
  endfunction

  function automatic logic genInRange(input logic [2:0] gen, input logic [2:0] maxGen);
    return (gen >= GEN_MIN) && (gen <= maxGen) && (gen <= GEN_MAX_ABS);
  endfunction

endpackage

// File: rtl/pipe_rate_change_ctrl_lane_status_collector.sv
// Sticky per-lane PhyStatus collection with a masked "every active lane seen" compare.
module lane_status_collector #(
  parameter int LANESNUMBER = 16
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [LANESNUMBER-1:0] phyStatus,
  input  logic [LANESNUMBER-1:0] laneMask,
  output logic                   allSeen
);

  logic [LANESNUMBER-1:0] phySeen;

  // Sticky OR of PhyStatus; held at zero while clear is asserted
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      phySeen <= {LANESNUMBER{1'b0}};
    end else if (clear) begin
      phySeen <= {LANESNUMBER{1'b0}};
    end else begin
      phySeen <= phySeen | phyStatus;
    end
  end

  // Current-cycle PhyStatus counts too, so a zero mask completes immediately
  assign allSeen = ((phySeen | phyStatus) & laneMask) == laneMask;

endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// PIPE rate / PCLK change sequencer: quiesce TX, drive Rate/PCLKRate, run the
// PclkChangeOk/Ack handshake, collect PhyStatus and report done or error.
module pipe_rate_change_ctrl
  import pcie_rate_defs::*;
#(
  parameter int LANESNUMBER    = 16,
  parameter int MAX_GEN        = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  input  logic [2:0]             req_gen,
  input  logic [LANESNUMBER-1:0] lane_mask,
  output logic                   req_ready,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             cur_gen,
  output logic                   elec_idle_req,
  input  logic                   elec_idle_ack,
  output logic [3:0]             Rate,
  output logic [4:0]             PCLKRate,
  output logic                   PclkChangeAck,
  input  logic                   PclkChangeOk,
  input  logic [LANESNUMBER-1:0] PhyStatus
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  MAX_GEN_L = 3'(MAX_GEN);

  rcState_e               state;
  logic [15:0]            tmoCnt;
  logic [2:0]             tgtGen;
  logic [LANESNUMBER-1:0] maskQ;
  logic                   allSeen;
  logic                   tmoHit;

  assign tmoHit = (tmoCnt == TMO_LAST);

  // Collector is held clear outside ACK, so it starts empty on every ACK entry
  lane_status_collector #(.LANESNUMBER(LANESNUMBER)) uCollector (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .clear     (state != ST_ACK),
    .phyStatus (PhyStatus),
    .laneMask  (maskQ),
    .allSeen   (allSeen)
  );

  // Sequencer FSM with registered outputs; exit conditions are tested before timeout
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      tmoCnt        <= 16'd0;
      tgtGen        <= 3'd0;
      maskQ         <= {LANESNUMBER{1'b0}};
      req_ready     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      cur_gen       <= 3'd1;
      elec_idle_req <= 1'b0;
      Rate          <= 4'd0;
      PCLKRate      <= 5'd0;
      PclkChangeAck <= 1'b0;
    end else begin
      done   <= 1'b0;
      error  <= 1'b0;
      tmoCnt <= tmoCnt + 16'd1;
      case (state)
        ST_IDLE: begin
          tmoCnt <= 16'd0;
          if (req_valid) begin
            tgtGen    <= req_gen;
            maskQ     <= lane_mask;
            req_ready <= 1'b0;
            if (!genInRange(req_gen, MAX_GEN_L)) begin
              state    <= ST_ABORT;
              Rate     <= genToRate(cur_gen);
              PCLKRate <= genToPclkRate(cur_gen);
            end else if (req_gen == cur_gen) begin
              state <= ST_DONE;
            end else begin
              state         <= ST_QUIESCE;
              elec_idle_req <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_QUIESCE: begin
          if (elec_idle_ack) begin
            state    <= ST_RATE;
            tmoCnt   <= 16'd0;
            Rate     <= genToRate(tgtGen);
            PCLKRate <= genToPclkRate(tgtGen);
          end else if (tmoHit) begin
            state    <= ST_ABORT;
            tmoCnt   <= 16'd0;
            Rate     <= genToRate(cur_gen);
            PCLKRate <= genToPclkRate(cur_gen);
          end else begin
            state <= ST_QUIESCE;
          end
        end
        ST_RATE: begin
          if (PclkChangeOk) begin
            state         <= ST_ACK;
            tmoCnt        <= 16'd0;
            PclkChangeAck <= 1'b1;
          end else if (tmoHit) begin
            state    <= ST_ABORT;
            tmoCnt   <= 16'd0;
            Rate     <= genToRate(cur_gen);
            PCLKRate <= genToPclkRate(cur_gen);
          end else begin
            state <= ST_RATE;
          end
        end
        ST_ACK: begin
          if (allSeen) begin
            state         <= ST_DONE;
            tmoCnt        <= 16'd0;
            PclkChangeAck <= 1'b0;
          end else if (tmoHit) begin
            state         <= ST_ABORT;
            tmoCnt        <= 16'd0;
            PclkChangeAck <= 1'b0;
            Rate          <= genToRate(cur_gen);
            PCLKRate      <= genToPclkRate(cur_gen);
          end else begin
            state <= ST_ACK;
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          tmoCnt        <= 16'd0;
          done          <= 1'b1;
          cur_gen       <= tgtGen;
          req_ready     <= 1'b1;
          elec_idle_req <= 1'b0;
        end
        ST_ABORT: begin
          state         <= ST_IDLE;
          tmoCnt        <= 16'd0;
          error         <= 1'b1;
          req_ready     <= 1'b1;
          elec_idle_req <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          tmoCnt        <= 16'd0;
          req_ready     <= 1'b1;
          elec_idle_req <= 1'b0;
          PclkChangeAck <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Scoreboard bench for pipe_rate_change_ctrl: a timeline model predicts each
// request's outcome, pulse cycle and handshake durations from the PHY delays.
module tb_pipe_rate_change_ctrl;

  localparam int L    = 16;
  localparam int MAXG = 3;
  localparam int T    = 8;

  logic         pclk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [2:0]   req_gen = 3'd0;
  logic [L-1:0] lane_mask = 16'h0000;
  logic         req_ready, done, error, elec_idle_req, PclkChangeAck;
  logic [2:0]   cur_gen;
  logic [3:0]   Rate;
  logic [4:0]   PCLKRate;
  logic         elec_idle_ack = 1'b0;
  logic         PclkChangeOk = 1'b0;
  logic [L-1:0] PhyStatus = 16'h0000;

  pipe_rate_change_ctrl #(.LANESNUMBER(L), .MAX_GEN(MAXG), .TIMEOUT_CYCLES(T)) dut (
    .pclk(pclk), .reset_n(reset_n), .req_valid(req_valid), .req_gen(req_gen),
    .lane_mask(lane_mask), .req_ready(req_ready), .done(done), .error(error),
    .cur_gen(cur_gen), .elec_idle_req(elec_idle_req), .elec_idle_ack(elec_idle_ack),
    .Rate(Rate), .PCLKRate(PCLKRate), .PclkChangeAck(PclkChangeAck),
    .PclkChangeOk(PclkChangeOk), .PhyStatus(PhyStatus)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    bit isErr; int tRate; int tAck; int tPulse; int ackCyc; int eirCyc; int newCur;
  } plan_t;
  typedef struct { bit isErr; int gen; int cyc; } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   modelCur = 1;
  int   laneOff[L];

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Outcome timeline in cycles after acceptance: each PHY wait of d cycles
  // finishes after d+1 cycles if d < T, otherwise the stage gives up after T.
  function automatic plan_t predict(input int gen, input int cur, input int dq, input int dr, input int need);
    plan_t p;
    int t;
    p.tRate = -1; p.tAck = -1; p.ackCyc = 0; p.eirCyc = 0; p.newCur = cur;
    if (gen < 1 || gen > MAXG) begin
      p.isErr = 1'b1; p.tPulse = 2; return p;
    end
    if (gen == cur) begin
      p.isErr = 1'b0; p.tPulse = 2; p.newCur = gen; return p;
    end
    p.isErr = 1'b1;
    t = 1;
    if (dq > T - 1) t += T;
    else begin
      t += dq + 1; p.tRate = t;
      if (dr > T - 1) t += T;
      else begin
        t += dr + 1; p.tAck = t;
        if (need > T - 1) begin t += T; p.ackCyc = T; end
        else begin t += need + 1; p.ackCyc = need + 1; p.isErr = 1'b0; p.newCur = gen; end
      end
    end
    p.eirCyc = t;
    p.tPulse = t + 1;
    return p;
  endfunction

  task automatic waitReady();
    for (int w = 0; w < 40 && req_ready !== 1'b1; w++) @(negedge pclk);
    if (req_ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 1);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_cur_gen"}, int'(cur_gen), 1);
    check({tag, "_elec_idle_req"}, int'(elec_idle_req), 0);
    check({tag, "_Rate"}, int'(Rate), 0);
    check({tag, "_PCLKRate"}, int'(PCLKRate), 0);
    check({tag, "_PclkChangeAck"}, int'(PclkChangeAck), 0);
  endtask

  task automatic runTxn(input int gen, input logic [L-1:0] mask, input int dq, input int dr, input bit noise);
    plan_t p;
    int need, ackSeen, eirSeen, rateBad, curBefore;
    bit phy;
    logic [L-1:0] ps;
    need = 0;
    for (int l = 0; l < L; l++) if (mask[l] && laneOff[l] > need) need = laneOff[l];
    @(negedge pclk);
    waitReady();
    curBefore = modelCur;
    p = predict(gen, modelCur, dq, dr, need);
    phy = (p.eirCyc > 0);
    req_valid = 1'b1; req_gen = 3'(gen); lane_mask = mask;
    expQ.push_back('{p.isErr, p.newCur, cyc + p.tPulse});
    modelCur = p.newCur;
    ackSeen = 0; eirSeen = 0; rateBad = 0;
    for (int k = 1; k <= p.tPulse; k++) begin
      @(negedge pclk);
      req_valid = (k < p.tPulse) ? 1'($urandom_range(1, 0)) : 1'b0;
      req_gen = 3'($urandom);
      lane_mask = 16'($urandom);
      elec_idle_ack = phy && (k >= 1 + dq) && (k < p.tPulse);
      PclkChangeOk = (p.tRate >= 0) && (k >= p.tRate + dr) && (k < p.tPulse);
      ps = noise ? (16'($urandom) & ~mask) : 16'h0000;
      if (p.tAck >= 0)
        for (int l = 0; l < L; l++) if (mask[l] && k == p.tAck + laneOff[l]) ps[l] = 1'b1;
      PhyStatus = ps;
      if (k == 1) check("ready_drops", int'(req_ready), 0);
      if (k < p.tPulse) begin
        ackSeen += int'(PclkChangeAck);
        eirSeen += int'(elec_idle_req);
      end
      if (!phy && int'(Rate) != curBefore - 1) rateBad++;
    end
    check("ready_back", int'(req_ready), 1);
    check("ack_cycles", ackSeen, p.ackCyc);
    check("elec_idle_cycles", eirSeen, p.eirCyc);
    if (!phy) check("rate_stable", rateBad, 0);
    PhyStatus = 16'h0000;
  endtask

  task automatic resetInAck();
    int gen;
    @(negedge pclk);
    waitReady();
    gen = (modelCur == 2) ? 3 : 2;
    req_valid = 1'b1; req_gen = 3'(gen); lane_mask = 16'hFFFF; PhyStatus = 16'h0000;
    @(negedge pclk);
    req_valid = 1'b0; elec_idle_ack = 1'b1;
    @(negedge pclk);
    PclkChangeOk = 1'b1;
    @(negedge pclk);
    check("ack_in_ack", int'(PclkChangeAck), 1);
    reset_n = 1'b0;
    @(negedge pclk);
    checkReset("reset_in_ack");
    reset_n = 1'b1; elec_idle_ack = 1'b0; PclkChangeOk = 1'b0;
    modelCur = 1;
  endtask

  // Monitor: every done/error pulse is matched against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (reset_n && (done || error)) begin
        check("done_error_exclusive", int'(done && error), 0);
        if (expQ.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          e = expQ.pop_front();
          check("pulse_is_error", int'(error), int'(e.isErr));
          check("pulse_cycle", cyc, e.cyc);
          check("cur_gen", int'(cur_gen), e.gen);
          check("Rate", int'(Rate), e.gen - 1);
          check("PCLKRate", int'(PCLKRate), e.gen - 1);
          check("ack_low_at_pulse", int'(PclkChangeAck), 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    for (int l = 0; l < L; l++) laneOff[l] = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge pclk);
    checkReset("por");
    reset_n = 1'b1;
    runTxn(1, 16'hFFFF, 0, 0, 1'b0);
    for (int l = 0; l < L; l++) laneOff[l] = 3;
    runTxn(2, 16'hFFFF, 3, 3, 1'b0);
    runTxn(4, 16'hFFFF, 0, 0, 1'b0);
    runTxn(0, 16'hFFFF, 0, 0, 1'b0);
    laneOff[0] = 1; laneOff[1] = 1; laneOff[2] = 6; laneOff[3] = 6;
    runTxn(3, 16'h000F, 2, 2, 1'b1);
    runTxn(1, 16'hFFFF, 0, 20, 1'b0);
    for (int l = 0; l < L; l++) laneOff[l] = 7;
    runTxn(2, 16'hFFFF, 7, 7, 1'b0);
    runTxn(3, 16'h0000, 1, 1, 1'b1);
    for (int n = 0; n < 40; n++) begin
      logic [L-1:0] m;
      for (int l = 0; l < L; l++) laneOff[l] = $urandom_range(9, 0);
      m = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
      runTxn($urandom_range(5, 0), m, $urandom_range(9, 0), $urandom_range(9, 0), 1'($urandom));
    end
    resetInAck();
    runTxn(1, 16'hFFFF, 0, 0, 1'b0);
    repeat (4) @(negedge pclk);
    check("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
